mem_lsu: RTL and testbench

//   Load/store initiator for the core's word-wide memory bus. Turns one CPU access
//   (RV32 LB/LH/LW/LBU/LHU/SB/SH/SW) into a single strobed bus transaction.

---
 rtl/mem_lsu_pkg.sv | 29 ++
 rtl/mem_lsu_if.sv | 43 ++++
 rtl/mem_lsu_align.sv | 74 +++++++
 rtl/mem_lsu.sv | 140 ++++++++++++++
 tb/tb_mem_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared widths, RV32 load/store width codes, FSM encoding and the held access context.
package mem_lsu_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MASK_W     = DATA_W / 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Access attributes kept from accept until the response is produced
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } acc_ctx_t;

endpackage

// File: rtl/mem_lsu_if.sv
// CPU request/response and word-bus signals of the load/store unit.
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rstrb;
  logic              mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rbusy;
  logic              mem_wbusy;

  // The LSU drives the memory bus and answers the CPU
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_addr, mem_wmask, mem_rstrb, mem_wstrb, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_rbusy, mem_wbusy,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_addr, mem_wmask, mem_rstrb, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and access legality check.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  output logic [MASK_W-1:0] wmask_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic              err_c,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data_c
);

  logic              illegal;
  logic              misaligned;
  logic [DATA_W-1:0] shifted;

  // Unsigned widths exist only for loads
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    misaligned = 1'b0;
      F3_H:    misaligned = off[0];
      F3_W:    misaligned = |off;
      F3_BU:   illegal    = we;
      F3_HU: begin
        illegal    = we;
        misaligned = off[0];
      end
      default: illegal    = 1'b1;
    endcase
    err_c = illegal | misaligned;
  end

  always_comb begin
    wmask_c = '0;
    wdata_c = '0;
    if (we) begin
      case (funct3)
        F3_B: begin
          wmask_c = MASK_W'(4'b0001 << off);
          wdata_c = {4{wdata[7:0]}};
        end
        F3_H: begin
          wmask_c = MASK_W'(4'b0011 << off);
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          wmask_c = '1;
          wdata_c = wdata;
        end
      endcase
    end
  end

  // Word loads are always aligned, so the shifted word equals rdata for them
  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data_c = {24'd0, shifted[7:0]};
      F3_HU:   ld_data_c = {16'd0, shifted[15:0]};
      default: ld_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: one CPU access becomes one strobed transaction on the word bus.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.master bus
);

  state_t            state;
  state_t            next_state;
  acc_ctx_t          ctx_q;
  logic              capture;

  logic [MASK_W-1:0] wmask_c;
  logic [DATA_W-1:0] wdata_c;
  logic              err_c;
  logic [DATA_W-1:0] ld_data_c;

  logic              ready_d;
  logic              rstrb_d;
  logic              wstrb_d;
  logic              resp_valid_d;
  logic              resp_err_d;
  logic [DATA_W-1:0] resp_rdata_d;

  logic              ready_q;
  logic              rstrb_q;
  logic              wstrb_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [MASK_W-1:0] mem_wmask_q;
  logic [DATA_W-1:0] mem_wdata_q;

  mem_lsu_align u_align (
    .we        (bus.req_we),
    .funct3    (bus.req_funct3),
    .off       (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .wmask_c   (wmask_c),
    .wdata_c   (wdata_c),
    .err_c     (err_c),
    .ld_funct3 (ctx_q.funct3),
    .ld_off    (ctx_q.off),
    .rdata     (bus.mem_rdata),
    .ld_data_c (ld_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state plus the next value of every registered output
  always_comb begin
    next_state   = state;
    capture      = 1'b0;
    rstrb_d      = 1'b0;
    wstrb_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (err_c) begin
            next_state   = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            next_state = ST_STROBE;
            capture    = 1'b1;
            rstrb_d    = !bus.req_we;
            wstrb_d    = bus.req_we;
          end
        end
      end
      ST_STROBE: next_state = ctx_q.we ? ST_WR_WAIT : ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!bus.mem_rbusy) begin
          next_state   = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_data_c;
        end
      end
      ST_WR_WAIT: begin
        if (!bus.mem_wbusy) begin
          next_state   = ST_RESP;
          resp_valid_d = 1'b1;
        end
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    ready_d = (next_state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b1;
      rstrb_q      <= 1'b0;
      wstrb_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
      ctx_q        <= '0;
    end else begin
      ready_q      <= ready_d;
      rstrb_q      <= rstrb_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if (capture) begin
        mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        mem_wmask_q <= wmask_c;
        mem_wdata_q <= wdata_c;
        ctx_q       <= '{we: bus.req_we, funct3: bus.req_funct3, off: bus.req_addr[1:0]};
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.mem_rstrb  = rstrb_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a response scoreboard and a cycle-accurate bus responder.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  exp_t sb[$];

  logic [31:0] lb_exp  [4] = '{32'hFFFFFFFE, 32'h00000001, 32'hFFFFFF80, 32'h0000007F};
  logic [31:0] lbu_exp [4] = '{32'h000000FE, 32'h00000001, 32'h00000080, 32'h0000007F};

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32)) bus ();

  mem_lsu #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access at the current cycle (T), act as responder, check strobes and response
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int busy,
                        input logic e_err, input logic [31:0] e_rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_wmask,
                        input logic [31:0] e_wdata);
    exp_t e;
    exp_t g;
    int   s;
    int   nr;
    int   nw;
    int   got;
    e.err   = e_err;
    e.rdata = e_rdata;
    e.lat   = e_err ? 1 : 3 + busy;
    sb.push_back(e);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_rdata  = rdata;
    bus.mem_rbusy  = 1'b0;
    bus.mem_wbusy  = 1'b0;
    s   = -1;
    nr  = 0;
    nw  = 0;
    got = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      tick();
      bus.req_valid = 1'b0;
      if (bus.mem_rstrb === 1'b1) nr++;
      if (bus.mem_wstrb === 1'b1) nw++;
      if ((bus.mem_rstrb === 1'b1 || bus.mem_wstrb === 1'b1) && s < 0) begin
        s = k;
        chk({tag, "_strobe_cycle"}, 32'(k), 32'd1);
        chk({tag, "_mem_addr"}, bus.mem_addr, e_addr);
        chk({tag, "_wmask"}, 32'(bus.mem_wmask), 32'(e_wmask));
        if (we) chk({tag, "_mem_wdata"}, bus.mem_wdata, e_wdata);
      end
      bus.mem_rbusy = (s >= 0) && !we && (k > s) && (k <= s + busy);
      bus.mem_wbusy = (s >= 0) &&  we && (k > s) && (k <= s + busy);
      if (bus.resp_valid === 1'b1) begin
        got = 1;
        if (sb.size() == 0) begin
          chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
          g = sb.pop_front();
          chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'(g.err));
          chk({tag, "_resp_rdata"}, bus.resp_rdata, g.rdata);
          chk({tag, "_latency"}, 32'(k), 32'(g.lat));
          if (!g.err) chk({tag, "_addr_hold"}, bus.mem_addr, e_addr);
        end
      end
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_rstrb_count"}, 32'(nr), (!e_err && !we) ? 32'd1 : 32'd0);
    chk({tag, "_wstrb_count"}, 32'(nw), (!e_err &&  we) ? 32'd1 : 32'd0);
    bus.mem_rbusy = 1'b0;
    bus.mem_wbusy = 1'b0;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rdata  = '0;
    bus.mem_rbusy  = 1'b0;
    bus.mem_wbusy  = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_strobes", 32'({bus.mem_rstrb, bus.mem_wstrb}), 32'd0);
    rst = 1'b0;
    tick();

    access("lw_basic", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0,
           1'b0, 32'hDEADBEEF, 32'h10, 4'h0, 32'h0);
    access("lb_sext", 1'b0, F3_B, 32'h13, 32'h0, 32'h80112233, 0,
           1'b0, 32'hFFFFFF80, 32'h10, 4'h0, 32'h0);
    access("lbu_zext", 1'b0, F3_BU, 32'h13, 32'h0, 32'h80112233, 0,
           1'b0, 32'h00000080, 32'h10, 4'h0, 32'h0);
    access("sh_upper", 1'b1, F3_H, 32'h22, 32'h0000ABCD, 32'h0, 0,
           1'b0, 32'h0, 32'h20, 4'b1100, 32'hABCDABCD);
    access("lw_busy3", 1'b0, F3_W, 32'h40, 32'h0, 32'h12345678, 3,
           1'b0, 32'h12345678, 32'h40, 4'h0, 32'h0);
    access("lh_misaligned", 1'b0, F3_H, 32'h05, 32'h0, 32'hFFFFFFFF, 0,
           1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
    access("sb_f3_3", 1'b1, 3'd3, 32'h08, 32'h12345678, 32'h0, 0,
           1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
    access("sb_lane1", 1'b1, F3_B, 32'h31, 32'hFFFFFF5A, 32'h0, 0,
           1'b0, 32'h0, 32'h30, 4'b0010, 32'h5A5A5A5A);
    access("sw_busy2", 1'b1, F3_W, 32'h44, 32'hCAFEF00D, 32'h0, 2,
           1'b0, 32'h0, 32'h44, 4'hF, 32'hCAFEF00D);
    access("lhu_hi", 1'b0, F3_HU, 32'h02, 32'h0, 32'h87654321, 0,
           1'b0, 32'h00008765, 32'h00, 4'h0, 32'h0);
    access("lh_hi", 1'b0, F3_H, 32'h02, 32'h0, 32'h87654321, 0,
           1'b0, 32'hFFFF8765, 32'h00, 4'h0, 32'h0);
    access("sw_misaligned", 1'b1, F3_W, 32'h46, 32'h1, 32'h0, 0,
           1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
    access("sh_bu_illegal", 1'b1, F3_BU, 32'h48, 32'h1, 32'h0, 0,
           1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
    access("ld_f3_6", 1'b0, 3'd6, 32'h48, 32'h0, 32'h0, 0,
           1'b1, 32'h0, 32'h0, 4'h0, 32'h0);

    for (int o = 0; o < 4; o++) begin
      access($sformatf("lb_off%0d", o), 1'b0, F3_B, 32'h60 + 32'(o), 32'h0, 32'h7F8001FE, 0,
             1'b0, lb_exp[o], 32'h60, 4'h0, 32'h0);
      access($sformatf("lbu_off%0d", o), 1'b0, F3_BU, 32'h60 + 32'(o), 32'h0, 32'h7F8001FE, 0,
             1'b0, lbu_exp[o], 32'h60, 4'h0, 32'h0);
    end

    // Store stalled by the responder, then reset while waiting for it
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h50;
    bus.req_wdata  = 32'h11111111;
    bus.mem_wbusy  = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("rstw_wstrb", 32'(bus.mem_wstrb), 32'd1);
    tick();
    chk("rstw_wait_no_strobe", 32'(bus.mem_wstrb), 32'd0);
    chk("rstw_wait_no_resp", 32'(bus.resp_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_wbusy = 1'b0;
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstw_mem_addr", bus.mem_addr, 32'd0);
    chk("rstw_wmask", 32'(bus.mem_wmask), 32'd0);
    chk("rstw_wdata", bus.mem_wdata, 32'd0);
    chk("rstw_strobes", 32'({bus.mem_rstrb, bus.mem_wstrb}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstw_no_resp%0d", k), 32'(bus.resp_valid), 32'd0);
    end

    access("lw_after_rst", 1'b0, F3_W, 32'h70, 32'h0, 32'hA5A5C3C3, 0,
           1'b0, 32'hA5A5C3C3, 32'h70, 4'h0, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
